cic3_row_readout_ctrl: RTL and testbench

Readout scheduler for one 2x12 row of CIC3 decimation filters. It runs a programmable capture counter on the common filter clock and snapshots all 24 25-bit filter outputs on the same cycle. It then drains the enabled channels one at a time through a single valid/ready port to the row's output serializer. It flags an overrun when a capture instant arrives before the previous frame has drained.

---
 rtl/cic3_row_readout_ctrl.sv | 135 +++++++++++++
 tb/tb_cic3_row_readout_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cic3_row_readout_ctrl.sv
// rtl/cic3_row_readout_ctrl.sv - capture/drain scheduler for one CIC3 filter row (optional CIC3_RO_PARITY_EN)
module cic3_row_readout_ctrl #(
  parameter int NUM_CHANNELS = 24,
  parameter int DATA_WIDTH   = 25,
  parameter int CNT_W        = 10,
  parameter int CHAN_W       = 5
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic [NUM_CHANNELS-1:0]            chan_mask,
  input  logic [CNT_W-1:0]                   capture_period,
  input  logic [CNT_W-1:0]                   capture_phase,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] filt_data,
  input  logic                               rd_ready,
  input  logic                               clear_overrun,
  output logic                               rd_valid,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic [CHAN_W-1:0]                  rd_chan,
  output logic                               rd_last,
  output logic                               busy,
  output logic                               overrun
`ifdef CIC3_RO_PARITY_EN
  ,
  output logic                               rd_parity
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [NUM_CHANNELS-1:0] pend;
  logic [DATA_WIDTH-1:0]   shadow [NUM_CHANNELS];
`ifdef CIC3_RO_PARITY_EN
  logic [NUM_CHANNELS-1:0] shadow_par;
  logic                    par_nxt;
`endif

  logic                    cap;
  logic                    load;
  logic                    hs;
  logic [NUM_CHANNELS-1:0] pend_clr;
  logic [NUM_CHANNELS-1:0] pend_nxt;
  logic [CHAN_W-1:0]       cur_nxt;
  logic                    last_nxt;
  logic                    valid_nxt;
  logic [DATA_WIDTH-1:0]   data_nxt;

  assign cap  = enable && (cnt == capture_phase);
  assign load = (state == IDLE) && cap && (chan_mask != '0);
  assign hs   = rd_valid && rd_ready;

  // Next pending set and the beat it exposes; outputs are registered from these so they stay stable under backpressure
  always_comb begin
    pend_clr = pend;
    if (hs) pend_clr[rd_chan] = 1'b0;
    pend_nxt  = load ? chan_mask : pend_clr;
    valid_nxt = (pend_nxt != '0);
    last_nxt  = valid_nxt && ((pend_nxt & (pend_nxt - 1'b1)) == '0);
    cur_nxt   = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (pend_nxt[i]) cur_nxt = CHAN_W'(i);
    end
    // On the capture cycle the snapshot is not yet in shadow, so take the first beat straight from the filter bus
    data_nxt = load ? filt_data[cur_nxt*DATA_WIDTH +: DATA_WIDTH] : shadow[cur_nxt];
`ifdef CIC3_RO_PARITY_EN
    par_nxt = load ? ^filt_data[cur_nxt*DATA_WIDTH +: DATA_WIDTH] : shadow_par[cur_nxt];
`endif
  end

  // Free-running capture counter, parked at zero while disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else begin
      cnt <= (cnt == capture_period) ? '0 : cnt + 1'b1;
    end
  end

  // Snapshot all channels on an accepted capture; held untouched for the rest of the frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CHANNELS; k++) shadow[k] <= '0;
`ifdef CIC3_RO_PARITY_EN
      shadow_par <= '0;
`endif
    end else if (load) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        shadow[k] <= filt_data[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef CIC3_RO_PARITY_EN
        shadow_par[k] <= ^filt_data[k*DATA_WIDTH +: DATA_WIDTH];
`endif
      end
    end
  end

  // Frame FSM with registered beat outputs and sticky overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pend     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_chan  <= '0;
      rd_last  <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
`ifdef CIC3_RO_PARITY_EN
      rd_parity <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (load) state <= SEND;
        SEND: if (hs && rd_last) state <= IDLE;
        default: state <= IDLE;
      endcase
      pend     <= pend_nxt;
      rd_valid <= valid_nxt;
      busy     <= valid_nxt;
      rd_last  <= last_nxt;
      rd_chan  <= valid_nxt ? cur_nxt : '0;
      rd_data  <= valid_nxt ? data_nxt : '0;
`ifdef CIC3_RO_PARITY_EN
      rd_parity <= valid_nxt && par_nxt;
`endif
      // A capture that finds a frame still in flight is lost; setting beats clearing in the same cycle
      if (cap && (state == SEND)) overrun <= 1'b1;
      else if (clear_overrun)     overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic3_row_readout_ctrl.sv
// tb/tb_cic3_row_readout_ctrl.sv - directed self-checking bench for cic3_row_readout_ctrl
module tb_cic3_row_readout_ctrl;
  localparam int NC = 24;
  localparam int DW = 25;
  localparam int CW = 10;
  localparam int HW = 5;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               enable;
  logic [NC-1:0]      chan_mask;
  logic [CW-1:0]      capture_period;
  logic [CW-1:0]      capture_phase;
  logic [NC*DW-1:0]   filt_data;
  logic               rd_ready;
  logic               clear_overrun;
  logic               rd_valid;
  logic [DW-1:0]      rd_data;
  logic [HW-1:0]      rd_chan;
  logic               rd_last;
  logic               busy;
  logic               overrun;
`ifdef CIC3_RO_PARITY_EN
  logic               rd_parity;
`endif

  int checks = 0;
  int errors = 0;

  cic3_row_readout_ctrl dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .chan_mask(chan_mask),
    .capture_period(capture_period), .capture_phase(capture_phase),
    .filt_data(filt_data), .rd_ready(rd_ready), .clear_overrun(clear_overrun),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_chan(rd_chan), .rd_last(rd_last),
    .busy(busy), .overrun(overrun)
`ifdef CIC3_RO_PARITY_EN
    , .rd_parity(rd_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_filt(input int add);
    for (int k = 0; k < NC; k++) filt_data[k*DW +: DW] = DW'(k*1000 + add);
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (!rd_valid && n < lim) begin
      tick;
      n++;
    end
  endtask

  // Check a full-mask frame with ready high: 24 back-to-back beats, then idle
  task automatic full_frame(input string tag);
    for (int k = 0; k < NC; k++) begin
      chk({tag, "_valid"}, 32'(rd_valid), 1);
      chk({tag, "_chan"},  32'(rd_chan), 32'(k));
      chk({tag, "_data"},  32'(rd_data), 32'(k*1000));
      chk({tag, "_last"},  32'(rd_last), 32'(k == NC-1));
      tick;
    end
    chk({tag, "_busy_end"}, 32'(busy), 0);
    chk({tag, "_valid_end"}, 32'(rd_valid), 0);
  endtask

  initial begin
    int n;
    int exp_k;
    bit done;
    bit seen;
    logic [NC-1:0] m;

    reset_n = 1'b0; enable = 1'b1; chan_mask = '1;
    capture_period = 10'd99; capture_phase = 10'd10;
    rd_ready = 1'b1; clear_overrun = 1'b0;
    set_filt(0);
    tick; tick;
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_data",  32'(rd_data), 0);
    chk("rst_chan",  32'(rd_chan), 0);
    chk("rst_last",  32'(rd_last), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_ovr",   32'(overrun), 0);

    // Test 1: full frame, capture at cnt==10
    reset_n = 1'b1;
    wait_valid(300, n);
    chk("t1_latency", 32'(n), 11);
    chk("t1_busy", 32'(busy), 1);
    full_frame("t1");
    chk("t1_ovr", 32'(overrun), 0);

    // Test 2: sparse mask 0x800005
    m = 24'h800005;
    chan_mask = m;
    wait_valid(300, n);
    chk("t2_latency", 32'(n), 76);
    chk("t2_c0", 32'(rd_chan), 0);  chk("t2_d0", 32'(rd_data), 0);     chk("t2_l0", 32'(rd_last), 0);
    tick;
    chk("t2_c1", 32'(rd_chan), 2);  chk("t2_d1", 32'(rd_data), 2000);  chk("t2_l1", 32'(rd_last), 0);
    tick;
    chk("t2_c2", 32'(rd_chan), 23); chk("t2_d2", 32'(rd_data), 23000); chk("t2_l2", 32'(rd_last), 1);
    tick;
    chk("t2_end", 32'(rd_valid), 0);

    // Test 3: throttled ready, period 15, overlapping captures
    enable = 1'b0; chan_mask = '1; rd_ready = 1'b0;
    tick;
    capture_period = 10'd15; capture_phase = 10'd0;
    enable = 1'b1;
    exp_k = 0; done = 1'b0;
    for (int c = 1; c <= 400 && !done; c++) begin
      tick;
      if (c == 1) set_filt(7);
      if (c == 16) chk("t3_ovr_pre", 32'(overrun), 0);
      if (c == 17) chk("t3_ovr_set", 32'(overrun), 1);
      if (c == 33) chk("t3_ovr_setwins", 32'(overrun), 1);
      clear_overrun = (c == 32);
      if (rd_valid) begin
        chk("t3_chan", 32'(rd_chan), 32'(exp_k));
        chk("t3_data", 32'(rd_data), 32'(exp_k*1000));
      end else begin
        chk("t3_valid", 32'(rd_valid), 1);
      end
      rd_ready = ((c % 3) == 2);
      if (rd_valid && rd_ready) begin
        exp_k++;
        if (exp_k == NC) begin
          enable = 1'b0;
          tick;
          chk("t3_busy_end", 32'(busy), 0);
          chk("t3_valid_end", 32'(rd_valid), 0);
          done = 1'b1;
        end
      end
    end
    chk("t3_done", 32'(done), 1);
    rd_ready = 1'b1;
    clear_overrun = 1'b1;
    tick;
    clear_overrun = 1'b0;
    chk("t3_ovr_clr", 32'(overrun), 0);

    // Test 4: empty mask, then enable low
    chan_mask = '0; capture_period = 10'd3; capture_phase = 10'd0; enable = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (rd_valid || overrun) seen = 1'b1;
    end
    chk("t4_mask0", 32'(seen), 0);
    enable = 1'b0; chan_mask = '1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (rd_valid || dut.cnt != '0) seen = 1'b1;
    end
    chk("t4_disabled", 32'(seen), 0);

    // Test 5: reset mid-frame
    set_filt(0);
    capture_period = 10'd99; capture_phase = 10'd10; enable = 1'b1;
    wait_valid(300, n);
    repeat (5) tick;
    chk("t5_beat5", 32'(rd_chan), 5);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(rd_valid), 0);
    chk("t5_rst_busy",  32'(busy), 0);
    chk("t5_rst_cnt",   32'(dut.cnt), 0);
    tick;
    reset_n = 1'b1;
    wait_valid(300, n);
    chk("t5_latency", 32'(n), 11);
    full_frame("t5");

`ifdef CIC3_RO_PARITY_EN
    // Test 6: parity of captured data
    enable = 1'b0;
    tick;
    filt_data[0 +: DW]  = 25'h1FFFFFF;
    filt_data[DW +: DW] = 25'h0000003;
    chan_mask = 24'h3; capture_period = 10'd7; capture_phase = 10'd0; enable = 1'b1;
    wait_valid(20, n);
    chk("t6_chan0", 32'(rd_chan), 0);
    chk("t6_par0", 32'(rd_parity), 1);
    tick;
    chk("t6_chan1", 32'(rd_chan), 1);
    chk("t6_par1", 32'(rd_parity), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
